// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op codes, op-class decode and default latencies
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU ops to the multiply class.
package mdu_pkg;

  localparam logic [3:0] MDU_OP_MULT  = 4'd0;
  localparam logic [3:0] MDU_OP_MULTU = 4'd1;
  localparam logic [3:0] MDU_OP_DIV   = 4'd2;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd3;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd4;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd5;
  localparam logic [3:0] MDU_OP_MADD  = 4'd6;
  localparam logic [3:0] MDU_OP_MADDU = 4'd7;
  localparam logic [3:0] MDU_OP_MSUB  = 4'd8;
  localparam logic [3:0] MDU_OP_MSUBU = 4'd9;

  localparam int MDU_MUL_LAT = 5;
  localparam int MDU_DIV_LAT = 10;

  typedef enum logic {ST_IDLE, ST_RUN} mdu_state_t;

  function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op <= MDU_OP_MULTU) || (op >= MDU_OP_MADD && op <= MDU_OP_MSUBU);
`else
    return op <= MDU_OP_MULTU;
`endif
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic is_mt(input logic [3:0] op);
    return (op == MDU_OP_MTHI) || (op == MDU_OP_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV) ||
           (op == MDU_OP_MADD) || (op == MDU_OP_MSUB);
  endfunction

  function automatic logic is_valid(input logic [3:0] op);
    return is_mul(op) || is_div(op) || is_mt(op);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - combinational signed/unsigned divider
// Quotient truncates toward zero; remainder follows the dividend sign.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_div_zero
);

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_mag_q;
  logic [WIDTH-1:0] w_mag_r;

  assign w_neg_a    = i_signed & i_dividend[WIDTH-1];
  assign w_neg_b    = i_signed & i_divisor[WIDTH-1];
  assign w_mag_a    = w_neg_a ? (~i_dividend + 1'b1) : i_dividend;
  assign w_mag_b    = w_neg_b ? (~i_divisor + 1'b1) : i_divisor;
  assign o_div_zero = (i_divisor == '0);

  // MIN/-1 falls out naturally: |MIN| is 2^(W-1) unsigned, negated back to MIN.
  always_comb begin
    w_mag_q = '0;
    w_mag_r = '0;
    if (!o_div_zero) begin
      w_mag_q = w_mag_a / w_mag_b;
      w_mag_r = w_mag_a % w_mag_b;
    end
  end

  assign o_quot = (w_neg_a ^ w_neg_b) ? (~w_mag_q + 1'b1) : w_mag_q;
  assign o_rem  = w_neg_a ? (~w_mag_r + 1'b1) : w_mag_r;

endmodule

// File: rtl/mdu_hilo_unit.sv
// rtl/mdu_hilo_unit.sv - multi-cycle mul/div unit with HI/LO and MTHI/MTLO rollback
// MDU_MADD_EN enables the multiply-accumulate ops and their adder.
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             int_req,
  input  logic             rollback,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  mdu_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_shadow;
  logic             r_sh_lo;
  logic             r_commit;
  logic             r_busy;
  logic             r_done;

  logic               w_sgn;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mres;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_hi_rb;
  logic [WIDTH-1:0]   w_lo_rb;

  assign w_sgn   = is_signed_op(r_op);
  assign w_ext_a = w_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b = w_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Accumulate uses HI/LO as they stand at completion, not at accept.
  always_comb begin
    w_mres = w_prod;
`ifdef MDU_MADD_EN
    if (r_op == MDU_OP_MADD || r_op == MDU_OP_MADDU)
      w_mres = {r_hi, r_lo} + w_prod;
    else if (r_op == MDU_OP_MSUB || r_op == MDU_OP_MSUBU)
      w_mres = {r_hi, r_lo} - w_prod;
`endif
  end

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .i_signed   (w_sgn),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );

  // Rollback is applied before a same-cycle start sees HI/LO.
  assign w_hi_rb = (rollback && r_commit && !r_sh_lo) ? r_shadow : r_hi;
  assign w_lo_rb = (rollback && r_commit &&  r_sh_lo) ? r_shadow : r_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= MDU_OP_MULT;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_shadow <= '0;
      r_sh_lo  <= 1'b0;
      r_commit <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_commit <= 1'b0;
      if (r_state == ST_RUN) begin
        if (rollback) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end else if (r_cnt == '0) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (is_div(r_op)) begin
            if (!w_div_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end else begin
            {r_hi, r_lo} <= w_mres;
          end
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end else begin
        r_hi <= w_hi_rb;
        r_lo <= w_lo_rb;
        if (start && !int_req && is_valid(op)) begin
          if (op == MDU_OP_MTHI) begin
            r_shadow <= w_hi_rb;
            r_sh_lo  <= 1'b0;
            r_hi     <= a;
            r_commit <= 1'b1;
          end else if (op == MDU_OP_MTLO) begin
            r_shadow <= w_lo_rb;
            r_sh_lo  <= 1'b1;
            r_lo     <= a;
            r_commit <= 1'b1;
          end else begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= is_div(op) ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// tb/tb_mdu_hilo_unit.sv - directed vector bench for mdu_hilo_unit
// Accumulate vectors are exercised only when MDU_MADD_EN is defined.
module tb_mdu_hilo_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        int_req = 1'b0;
  logic        rollback = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  mdu_hilo_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .int_req  (int_req),
    .rollback (rollback),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb);
    start = 1'b1;
    op = o;
    a = xa;
    b = xb;
    step();
    start = 1'b0;
  endtask

  task automatic preload(input logic [31:0] vh, input logic [31:0] vl);
    issue(4'd4, vh, 32'd0);
    issue(4'd5, vl, 32'd0);
  endtask

  // Runs a mul/div op and returns the number of cycles busy was seen high.
  task automatic run_wait(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    logic [31:0] sh, sl;

    vecs.push_back('{4'd0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vecs.push_back('{4'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5});
    vecs.push_back('{4'd0, 32'h80000000, 32'h80000000, 32'h1, 32'h1, 32'h40000000, 32'h0, 5});
    vecs.push_back('{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h1, 5});
    vecs.push_back('{4'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{4'd2, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFD, 10});
    vecs.push_back('{4'd3, 32'd7, 32'd0, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 10});
    vecs.push_back('{4'd2, 32'd5, 32'd0, 32'hAAAA5555, 32'h5555AAAA, 32'hAAAA5555, 32'h5555AAAA, 10});
    vecs.push_back('{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h9, 32'h9, 32'h0, 32'h80000000, 10});
    vecs.push_back('{4'd3, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0, 32'hF, 32'h0FFFFFFF, 10});
`ifdef MDU_MADD_EN
    vecs.push_back('{4'd7, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5});
    vecs.push_back('{4'd6, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h10, 32'h0, 32'hA, 5});
    vecs.push_back('{4'd9, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5});
    vecs.push_back('{4'd8, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 32'h0, 32'h2, 5});
`endif

    step();
    step();
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      run_wait(n);
      chk($sformatf("v%0d_lat", i), n, vecs[i].lat);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      step();
      chk($sformatf("v%0d_done_clr", i), done, 0);
    end

    // MTHI rollback restores the old HI; an un-rolled-back MTHI sticks.
    issue(4'd4, 32'hA5A5A5A5, 0);
    step();
    issue(4'd4, 32'h12345678, 0);
    chk("mthi_write", hi, 32'h12345678);
    chk("mthi_busy", busy, 0);
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("mthi_rollback", hi, 32'hA5A5A5A5);
    issue(4'd4, 32'h12345678, 0);
    step();
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("mthi_late_rollback", hi, 32'h12345678);

    // MTLO rollback.
    issue(4'd5, 32'hCAFEF00D, 0);
    step();
    issue(4'd5, 32'h0BADBEEF, 0);
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("mtlo_rollback", lo, 32'hCAFEF00D);
    chk("mtlo_rb_hi", hi, 32'h12345678);

    // Rollback mid-RUN aborts: no write, no done.
    preload(32'h01010101, 32'h02020202);
    step();
    issue(4'd0, 32'd100, 32'd100);
    step();
    step();
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("abort_busy", busy, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) n++;
      step();
    end
    chk("abort_no_done", n, 0);
    chk("abort_hi", hi, 32'h01010101);
    chk("abort_lo", lo, 32'h02020202);

    // start with int_req is ignored.
    int_req = 1'b1;
    issue(4'd5, 32'd5, 0);
    chk("int_mtlo_lo", lo, 32'h02020202);
    issue(4'd0, 32'd5, 32'd5);
    int_req = 1'b0;
    chk("int_mult_busy", busy, 0);

    // Invalid op is ignored.
    issue(4'd12, 32'd3, 32'd3);
    chk("bad_op_busy", busy, 0);
`ifndef MDU_MADD_EN
    issue(4'd6, 32'd3, 32'd3);
    chk("madd_off_busy", busy, 0);
    chk("madd_off_lo", lo, 32'h02020202);
`endif

    // start during RUN ignored; start in done cycle accepted.
    issue(4'd1, 32'd6, 32'd7);
    issue(4'd5, 32'h77, 0);
    chk("run_busy", busy, 1);
    run_wait(n);
    chk("run_ign_lo", lo, 32'd42);
    chk("run_ign_hi", hi, 32'd0);
    chk("b2b_done", done, 1);
    issue(4'd1, 32'd2, 32'd3);
    chk("b2b_busy", busy, 1);
    run_wait(n);
    chk("b2b_lat", n, 5);
    chk("b2b_lo", lo, 32'd6);
    step();

    // Async reset mid-RUN.
    preload(32'h55, 32'h66);
    issue(4'd2, 32'd100, 32'd7);
    step();
    reset = 1'b1;
    #1;
    chk("rst_run_hi", hi, 0);
    chk("rst_run_lo", lo, 0);
    chk("rst_run_busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    chk("rst_after_busy", busy, 0);
    chk("rst_after_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers; successor to the fixed 32-bit mult/div block in the EX stage.
- Accepts one op per start pulse from EX and runs it over a configurable latency, asserting busy meanwhile.
- Commits results to HI/LO only on completion.
- Supports interrupt cancellation (int_req) and one-cycle rollback of a just-committed MTHI/MTLO, so precise exceptions hold.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, busy cycles for multiply-class ops (>=1).
- DIV_LAT, 10, busy cycles for divide-class ops (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  op valid in EX this cycle.
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; others are no-ops.
- a  in  WIDTH  rs operand, already forwarded.
- b  in  WIDTH  rt operand, already forwarded.
- int_req  in  1  interrupt/exception taken this cycle; EX instruction flushed.
- rollback  in  1  instruction that was in EX last cycle is cancelled.
- busy  out  1  op in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO first show a new mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, done=0, counter=0, shadow registers=0, state IDLE.
- States: IDLE, RUN.
- Acceptance: IDLE & start & !int_req & op valid → op accepted at that edge.
  - start with int_req high is ignored.
  - start while RUN is ignored; the pipeline stalls on busy.
  - Invalid op codes are ignored.
- MTHI/MTLO: accepted op writes hi (or lo) = a at that edge.
  - Before the write, the old value is copied to shadow and commit_flag is set.
  - Stays IDLE; busy stays 0; no done pulse.
- Mul/div ops:
  - Operands and op are latched at the accept edge; counter loads LAT-1 (MUL_LAT for mul/madd/msub, DIV_LAT for div).
  - State goes to RUN; busy=1 from the next cycle, for exactly LAT cycles.
  - At the edge ending the last RUN cycle: HI/LO are written, state returns to IDLE, busy=0, done=1 for one cycle.
  - A new start is accepted in the cycle done is high.
- Arithmetic:
  - MULT/MULTU: full 2*WIDTH product, signed or unsigned; {hi,lo}=product.
  - DIV/DIVU: lo=quotient, hi=remainder.
    - Signed divide truncates toward zero; remainder takes the sign of the dividend.
    - Divide by zero: full latency elapses, HI/LO unchanged, done still pulses.
    - Signed MIN/-1: lo=MIN, hi=0.
  - MADD(U)/MSUB(U): {hi,lo} = {hi,lo} ± product, mod 2^(2*WIDTH).
    - The hi/lo value used is the one present at completion.
- rollback:
  - In RUN: abort the op; state→IDLE, busy=0 next cycle, no HI/LO write, no done.
  - In IDLE with commit_flag set: restore hi or lo from shadow.
  - commit_flag clears every edge unless it is freshly set that edge.
  - If rollback and a new start arrive in the same cycle, rollback acts first and the start is still evaluated; in RUN the start is ignored.
- int_req alone does not abort RUN; only rollback does.
- Asserting reset mid-RUN discards the op; all outputs return to reset values.

Optional Feature:
- MDU_MADD_EN:
  - Defined: ops 6-9 are supported as described.
  - Undefined: ops 6-9 are invalid (ignored, never set busy), and the accumulate adder is removed.

Decomposition:
- Shared package mdu_pkg holds the op-code constants (MDU_OP_MULT … MDU_OP_MSUBU), the op-class decode functions is_mul/is_div/is_mt, and the default latency constants.
- One sub-module, mdu_divider: a combinational/sequential WIDTH-bit signed/unsigned divider producing quotient and remainder with the div-by-zero and overflow rules.
- The top level owns the FSM, the counter, HI/LO, and the shadow/rollback logic.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 → HI/LO unchanged, done pulses after 10 cycles.
- MTHI a=0x12345678 (old hi=0xA5A5A5A5), rollback next cycle → hi=0xA5A5A5A5; without rollback → hi=0x12345678.
- MULT started, rollback 3 cycles in → busy drops next cycle, HI/LO unchanged, no done.
- start with int_req=1 (MTLO a=5) → lo unchanged, busy stays 0.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0; reset asserted mid-RUN → hi=lo=0, busy=0 immediately.
